// File: rtl/cpu_ctrl_fsm_pkg.sv
// Shared types for the cpu_ctrl_fsm control sequencer:
// opcodes, FSM states, instruction fields and opcode class helpers.
package cpu_ctrl_fsm_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_ADDI = 4'h4,
        OP_SUBI = 4'h5,
        OP_SHL  = 4'h6,
        OP_SHR  = 4'h7,
        OP_MOVI = 4'h8,
        OP_BEQ  = 4'h9,
        OP_BLT  = 4'hA,
        OP_BGT  = 4'hB,
        OP_LD   = 4'hC,
        OP_ST   = 4'hD,
        OP_NOP  = 4'hE,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_WB,
        ST_HALTED
    } state_e;

    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int A_HI  = 11;
    localparam int A_LO  = 8;
    localparam int B_HI  = 7;
    localparam int B_LO  = 4;
    localparam int C_HI  = 3;
    localparam int C_LO  = 0;

    function automatic logic is_rtype(input logic [3:0] op);
        return op <= 4'h3;
    endfunction

    function automatic logic is_stype(input logic [3:0] op);
        return (op >= 4'h4) && (op <= 4'h8);
    endfunction

    function automatic logic is_btype(input logic [3:0] op);
        return (op >= 4'h9) && (op <= 4'hB);
    endfunction

    function automatic logic is_ltype(input logic [3:0] op);
        return (op == 4'hC) || (op == 4'hD);
    endfunction

endpackage

// File: rtl/cpu_ctrl_fsm_branch_cond.sv
// Branch resolution: opcode plus ALU zero/neg flags to taken.
module cpu_ctrl_fsm_branch_cond
    import cpu_ctrl_fsm_pkg::*;
(
    input  opcode_e i_op,
    input  logic    i_zero,
    input  logic    i_neg,
    output logic    o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_op)
            OP_BEQ:  o_taken = i_zero;
            OP_BLT:  o_taken = i_neg & ~i_zero;
            OP_BGT:  o_taken = ~i_neg & ~i_zero;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle control sequencer for the 16-bit RISC core.
// Owns PC, IR and the retire counter; drives fetch, decode, ALU and memory.
module cpu_ctrl_fsm
    import cpu_ctrl_fsm_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             imem_req,
    output logic [15:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ack,
    output logic [3:0]       alu_op,
    output logic [3:0]       imm4,
    input  logic             alu_zero,
    input  logic             alu_neg,
    input  logic             alu_ovf,
    output logic [3:0]       rf_raddr1,
    output logic [3:0]       rf_raddr2,
    output logic [3:0]       rf_waddr,
    output logic             rf_we,
    output logic             wb_sel,
    output logic [15:0]      pc,
    output logic             halted,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] retired
);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [15:0]      r_pc;
    logic [15:0]      r_ir;
    logic [CNT_W-1:0] r_retired;
    logic             r_ovf;
    opcode_e          w_op;
    logic [3:0]       w_a;
    logic [3:0]       w_b;
    logic [3:0]       w_c;
    logic             w_taken;
    logic             w_retire;

    assign w_op = opcode_e'(r_ir[OP_HI:OP_LO]);
    assign w_a  = r_ir[A_HI:A_LO];
    assign w_b  = r_ir[B_HI:B_LO];
    assign w_c  = r_ir[C_HI:C_LO];

    cpu_ctrl_fsm_branch_cond u_branch_cond (
        .i_op    (w_op),
        .i_zero  (alu_zero),
        .i_neg   (alu_neg),
        .o_taken (w_taken)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_retire    = 1'b0;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_op      = 4'h0;
        rf_raddr1   = 4'h0;
        rf_raddr2   = 4'h0;
        rf_we       = 1'b0;
        wb_sel      = 1'b0;
        // Read ports stay on the instruction's operands from decode to mem.
        if (r_state == ST_DECODE || r_state == ST_EXEC || r_state == ST_MEM) begin
            if (is_rtype(w_op)) begin
                rf_raddr1 = w_b;
                rf_raddr2 = w_c;
            end else if (is_stype(w_op)) begin
                rf_raddr1 = w_b;
            end else if (is_btype(w_op)) begin
                rf_raddr1 = w_a;
                rf_raddr2 = w_b;
            end else if (is_ltype(w_op)) begin
                rf_raddr1 = w_b;
                if (w_op == OP_ST) rf_raddr2 = w_a;
            end
        end
        case (r_state)
            ST_IDLE: begin
                if (start) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) w_state_nxt = ST_DECODE;
            end
            ST_DECODE: begin
                if (w_op == OP_HALT) begin
                    w_state_nxt = ST_HALTED;
                end else if (w_op == OP_NOP) begin
                    w_retire    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end else begin
                    w_state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                alu_op = w_op;
                if (is_ltype(w_op)) begin
                    w_state_nxt = ST_MEM;
                end else begin
                    rf_we       = is_rtype(w_op) || is_stype(w_op);
                    w_retire    = 1'b1;
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_MEM: begin
                alu_op   = w_op;
                dmem_req = 1'b1;
                dmem_we  = (w_op == OP_ST);
                if (dmem_ack) begin
                    w_retire    = (w_op == OP_ST);
                    w_state_nxt = (w_op == OP_ST) ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                rf_we       = 1'b1;
                wb_sel      = 1'b1;
                w_retire    = 1'b1;
                w_state_nxt = ST_FETCH;
            end
            ST_HALTED: begin
                w_state_nxt = ST_HALTED;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc      <= RESET_PC;
            r_ir      <= 16'h0000;
            r_retired <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (r_state == ST_FETCH && imem_ack) begin
                r_ir <= imem_rdata;
                r_pc <= r_pc + 16'd1;
            end
            // pc already points past the branch when the offset is applied.
            if (r_state == ST_EXEC) begin
                if (w_taken) r_pc <= r_pc + {{12{w_c[3]}}, w_c};
                if (alu_ovf && (w_op == OP_ADD || w_op == OP_SUB)) r_ovf <= 1'b1;
            end
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
        end
    end

    assign imem_addr  = r_pc;
    assign pc         = r_pc;
    assign imm4       = w_c;
    assign rf_waddr   = w_a;
    assign halted     = (r_state == ST_HALTED);
    assign ovf_sticky = r_ovf;
    assign retired    = r_retired;

endmodule
